// File: rtl/sd_init_seq.sv
`timescale 1ns/1ps
// SPI-mode SD card power-up sequencer: sends the 0xFF dummy bytes directly on the SPI bus, then steps
// the command engine through CMD0, CMD8, CMD55/ACMD41 and CMD16 and reports the outcome.
module sd_init_seq #(
    parameter int DUMMY_BYTES  = 10,
    parameter int CMD0_TRIES   = 8,
    parameter int ACMD41_TRIES = 1000,
    parameter int WAIT_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        card_v2,
    output logic        cmd_w,
    output logic [47:0] cmd,
    input  logic        cmd_busy,
    input  logic [39:0] cmd_resp,
    output logic        sel,
    output logic        spi_cs,
    output logic        spi_w,
    output logic [7:0]  spi_data,
    input  logic        spi_busy
);
    localparam int BW = $clog2(DUMMY_BYTES + 1);
    localparam int CW = $clog2(CMD0_TRIES + 1);
    localparam int AW = $clog2(ACMD41_TRIES + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(DUMMY_BYTES - 1);
    localparam logic [CW-1:0] CMD0_LAST = CW'(CMD0_TRIES - 1);
    localparam logic [AW-1:0] ACMD_LAST = AW'(ACMD41_TRIES - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY_W, S_DUMMY_WAIT, S_ISSUE, S_CMD_START, S_CMD_DONE, S_EVAL, S_DONE, S_ERROR
    } state_t;
    typedef enum logic [2:0] {STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD16} step_t;

    function automatic logic [47:0] frame_for(input step_t step, input logic v2);
        logic [47:0] f;
        case (step)
            STEP_CMD0:   f = 48'h40_00000000_95;
            STEP_CMD8:   f = 48'h48_000001AA_87;
            STEP_CMD55:  f = 48'h77_00000000_65;
            STEP_ACMD41: f = v2 ? 48'h69_40000000_77 : 48'h69_00000000_E5;
            STEP_CMD16:  f = 48'h50_00000200_15;
            default:     f = 48'h40_00000000_95;
        endcase
        return f;
    endfunction

    state_t        state_q, state_d;
    step_t         step_q, step_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] cmd0_cnt_q, cmd0_cnt_d;
    logic [AW-1:0] acmd_cnt_q, acmd_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          spi_seen_q, spi_seen_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [2:0]    err_code_q, err_code_d;
    logic          card_v2_q, card_v2_d, cmd_w_q, cmd_w_d;
    logic [47:0]   cmd_q, cmd_d;
    logic          sel_q, sel_d, spi_cs_q, spi_cs_d, spi_w_q, spi_w_d;

    logic [7:0]    r1_s;
    logic [11:0]   echo_s;
    logic          fail_s, wait_s, abort_s, resp_unused_s;
    logic [2:0]    fail_code_s;

    assign r1_s          = cmd_resp[39:32];
    assign echo_s        = cmd_resp[11:0];
    assign resp_unused_s = ^cmd_resp[31:12];

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        byte_cnt_d  = byte_cnt_q;
        cmd0_cnt_d  = cmd0_cnt_q;
        acmd_cnt_d  = acmd_cnt_q;
        wdog_d      = {WW{1'b0}};
        spi_seen_d  = spi_seen_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        card_v2_d   = card_v2_q;
        cmd_w_d     = 1'b0;
        cmd_d       = cmd_q;
        sel_d       = sel_q;
        spi_cs_d    = 1'b1;
        spi_w_d     = 1'b0;
        fail_s      = 1'b0;
        fail_code_s = 3'd0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_DUMMY_W;
                    step_d     = STEP_CMD0;
                    byte_cnt_d = {BW{1'b0}};
                    cmd0_cnt_d = {CW{1'b0}};
                    acmd_cnt_d = {AW{1'b0}};
                    spi_seen_d = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 3'd0;
                    card_v2_d  = 1'b0;
                    sel_d      = 1'b1;
                    spi_w_d    = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_DUMMY_W: begin
                spi_seen_d = 1'b0;
                state_d    = S_DUMMY_WAIT;
            end
            S_DUMMY_WAIT: begin
                // A byte is finished only after busy has been seen high and has dropped again.
                if (!spi_seen_q) begin
                    spi_seen_d = spi_busy;
                end else if (!spi_busy) begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (byte_cnt_q == BYTE_LAST) begin
                        sel_d   = 1'b0;
                        step_d  = STEP_CMD0;
                        state_d = S_ISSUE;
                    end else begin
                        spi_w_d = 1'b1;
                        state_d = S_DUMMY_W;
                    end
                end else begin
                    spi_seen_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!cmd_busy) begin
                    cmd_d   = frame_for(step_q, card_v2_q);
                    cmd_w_d = 1'b1;
                    state_d = S_CMD_START;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_CMD_START: begin
                if (cmd_busy) begin
                    state_d = S_CMD_DONE;
                end else begin
                    state_d = S_CMD_START;
                end
            end
            S_CMD_DONE: begin
                if (!cmd_busy) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_CMD_DONE;
                end
            end
            S_EVAL: begin
                state_d = S_ISSUE;
                case (step_q)
                    STEP_CMD0: begin
                        if (r1_s == 8'h01) begin
                            step_d = STEP_CMD8;
                        end else if (cmd0_cnt_q == CMD0_LAST) begin
                            fail_s = 1'b1; fail_code_s = 3'd1;
                        end else begin
                            cmd0_cnt_d = cmd0_cnt_q + CW'(1);
                        end
                    end
                    STEP_CMD8: begin
                        // Illegal-command R1 marks a v1 card; otherwise the voltage echo must match.
                        if (r1_s[2]) begin
                            card_v2_d = 1'b0; step_d = STEP_CMD55;
                        end else if (r1_s == 8'h01 && echo_s == 12'h1AA) begin
                            card_v2_d = 1'b1; step_d = STEP_CMD55;
                        end else begin
                            fail_s = 1'b1; fail_code_s = 3'd2;
                        end
                    end
                    STEP_CMD55: begin
                        if (r1_s[7:1] != 7'd0) begin
                            fail_s = 1'b1; fail_code_s = 3'd4;
                        end else begin
                            step_d = STEP_ACMD41;
                        end
                    end
                    STEP_ACMD41: begin
                        if (r1_s == 8'h00) begin
                            step_d = STEP_CMD16;
                        end else if (r1_s == 8'h01 && acmd_cnt_q == ACMD_LAST) begin
                            fail_s = 1'b1; fail_code_s = 3'd3;
                        end else if (r1_s == 8'h01) begin
                            acmd_cnt_d = acmd_cnt_q + AW'(1);
                            step_d     = STEP_CMD55;
                        end else begin
                            fail_s = 1'b1; fail_code_s = 3'd4;
                        end
                    end
                    STEP_CMD16: begin
                        if (r1_s == 8'h00) begin
                            state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0;
                        end else begin
                            fail_s = 1'b1; fail_code_s = 3'd5;
                        end
                    end
                    default: begin
                        fail_s = 1'b1; fail_code_s = 3'd4;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        wait_s  = (state_q == S_DUMMY_WAIT) || (state_q == S_CMD_START) || (state_q == S_CMD_DONE);
        abort_s = fail_s || (wait_s && state_d == state_q && wdog_q == WDOG_LAST);
        if (abort_s) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = fail_s ? fail_code_s : 3'd6;
            busy_d     = 1'b0;
            sel_d      = 1'b0;
            spi_w_d    = 1'b0;
        end else if (wait_s && state_d == state_q) begin
            wdog_d = wdog_q + WW'(1);
        end else begin
            wdog_d = {WW{1'b0}};
        end
    end

    // Sequencer registers; reset parks everything in IDLE with the SPI bus owned here and CS high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= STEP_CMD0;
            byte_cnt_q <= {BW{1'b0}};
            cmd0_cnt_q <= {CW{1'b0}};
            acmd_cnt_q <= {AW{1'b0}};
            wdog_q     <= {WW{1'b0}};
            spi_seen_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
            card_v2_q  <= 1'b0;
            cmd_w_q    <= 1'b0;
            cmd_q      <= 48'h0;
            sel_q      <= 1'b1;
            spi_cs_q   <= 1'b1;
            spi_w_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            byte_cnt_q <= byte_cnt_d;
            cmd0_cnt_q <= cmd0_cnt_d;
            acmd_cnt_q <= acmd_cnt_d;
            wdog_q     <= wdog_d;
            spi_seen_q <= spi_seen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            card_v2_q  <= card_v2_d;
            cmd_w_q    <= cmd_w_d;
            cmd_q      <= cmd_d;
            sel_q      <= sel_d;
            spi_cs_q   <= spi_cs_d;
            spi_w_q    <= spi_w_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign card_v2  = card_v2_q;
    assign cmd_w    = cmd_w_q;
    assign cmd      = cmd_q;
    assign sel      = sel_q;
    assign spi_cs   = spi_cs_q;
    assign spi_w    = spi_w_q;
    assign spi_data = 8'hFF;
endmodule

// File: tb/tb_sd_init_seq.sv
`timescale 1ns/1ps
// Bench for sd_init_seq: behavioural SD card / command engine and SPI master models, with a frame
// scoreboard filled per scenario and drained as the sequencer issues commands.
module tb_sd_init_seq;
    localparam logic [47:0] F_CMD0   = 48'h40_00000000_95;
    localparam logic [47:0] F_CMD8   = 48'h48_000001AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_00000000_65;
    localparam logic [47:0] F_A41_V2 = 48'h69_40000000_77;
    localparam logic [47:0] F_A41_V1 = 48'h69_00000000_E5;
    localparam logic [47:0] F_CMD16  = 48'h50_00000200_15;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic busy, done, error, card_v2, cmd_w, sel, spi_cs, spi_w;
    logic [2:0] err_code;
    logic [47:0] cmd;
    logic [7:0] spi_data;
    logic cmd_busy = 1'b0, spi_busy = 1'b0;
    logic [39:0] cmd_resp = 40'h0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];

    logic [7:0]  cmd0_r1 = 8'h01;
    logic [39:0] cmd8_resp = 40'h01_000001AA;
    int          acmd_busy_n = 0;
    logic [7:0]  cmd16_r1 = 8'h00;
    logic        eng_dead = 1'b0;
    logic [2:0]  eng_cnt = 3'd0, spi_cnt = 3'd0;
    int          acmd_seen = 0;

    always #5 clk = ~clk;

    sd_init_seq #(.ACMD41_TRIES(4), .WAIT_TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .card_v2(card_v2), .cmd_w(cmd_w), .cmd(cmd), .cmd_busy(cmd_busy),
        .cmd_resp(cmd_resp), .sel(sel), .spi_cs(spi_cs), .spi_w(spi_w), .spi_data(spi_data),
        .spi_busy(spi_busy)
    );

    // Command engine + card: busy for three cycles after each strobe, reply chosen by command index.
    always @(posedge clk) begin
        if (reset) begin
            cmd_busy <= 1'b0; eng_cnt <= 3'd0; acmd_seen <= 0;
        end else if (cmd_w && !eng_dead) begin
            cmd_busy <= 1'b1; eng_cnt <= 3'd3;
            case (cmd[47:40])
                8'h40: begin cmd_resp <= {cmd0_r1, 32'h0}; acmd_seen <= 0; end
                8'h48: cmd_resp <= cmd8_resp;
                8'h77: cmd_resp <= {8'h01, 32'h0};
                8'h69: begin
                    cmd_resp  <= {(acmd_seen < acmd_busy_n) ? 8'h01 : 8'h00, 32'h0};
                    acmd_seen <= acmd_seen + 1;
                end
                8'h50: cmd_resp <= {cmd16_r1, 32'h0};
                default: cmd_resp <= 40'hFF_FFFFFFFF;
            endcase
        end else if (eng_cnt != 3'd0) begin
            eng_cnt <= eng_cnt - 3'd1;
            if (eng_cnt == 3'd1) cmd_busy <= 1'b0;
        end
    end

    // SPI master: one byte keeps busy high for four cycles.
    always @(posedge clk) begin
        if (reset) begin
            spi_busy <= 1'b0; spi_cnt <= 3'd0;
        end else if (spi_w) begin
            spi_busy <= 1'b1; spi_cnt <= 3'd4;
        end else if (spi_cnt != 3'd0) begin
            spi_cnt <= spi_cnt - 3'd1;
            if (spi_cnt == 3'd1) spi_busy <= 1'b0;
        end
    end

    task automatic set_profile(input logic [7:0] r0, input logic [39:0] r8, input int a41_busy, input logic [7:0] r16);
        cmd0_r1 = r0; cmd8_resp = r8; acmd_busy_n = a41_busy; cmd16_r1 = r16;
    endtask

    task automatic push_seq(input logic v2, input int a41_iters, input bit with_cmd16);
        exp_q.push_back(F_CMD0);
        exp_q.push_back(F_CMD8);
        for (int i = 0; i < a41_iters; i++) begin
            exp_q.push_back(F_CMD55);
            exp_q.push_back(v2 ? F_A41_V2 : F_A41_V1);
        end
        if (with_cmd16) exp_q.push_back(F_CMD16);
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || spi_w !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_accept: busy=%b spi_w=%b error=%b done=%b, required 1 1 0 0", busy, spi_w, error, done);
        end
    endtask

    // Runs from the current negedge until done/error (or first ACMD41 frame), draining the scoreboard.
    task automatic run_to_end(input int max_c, input int poke_a, input int poke_b, input bit stop_a41,
                              output int pulses, output int cmd_c, output int end_c);
        int cs_bad = 0;
        bit fin = 1'b0;
        logic [47:0] f;
        pulses = 0; cmd_c = -1; end_c = -1;
        for (int c = 0; c < max_c && !fin; c++) begin
            if (c != 0) @(negedge clk);
            start = (c == poke_a) || (c == poke_b);
            if (spi_w === 1'b1) pulses++;
            if (spi_cs !== 1'b1 || (spi_w === 1'b1 && sel !== 1'b1)) cs_bad++;
            if (cmd_w === 1'b1) begin
                if (cmd_c < 0) cmd_c = c;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_unexpected: got %h, required no frame", cmd);
                end else begin
                    f = exp_q.pop_front();
                    if (cmd !== f) begin
                        n_bad++;
                        $display("FAIL frame_seq: got %h, required %h", cmd, f);
                    end
                end
                if (stop_a41 && cmd[47:40] == 8'h69) begin fin = 1'b1; end_c = c; end
            end
            if (done === 1'b1 || error === 1'b1) begin fin = 1'b1; end_c = c; end
        end
        start = 1'b0;
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL run_timeout: ran %0d cycles, required completion", max_c); end
        n_cmp++;
        if (cs_bad != 0) begin n_bad++; $display("FAIL spi_direct: %0d bad cycles, required 0", cs_bad); end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL frames_missing: %0d frames not issued, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, err_code, card_v2, cmd_w, sel, spi_cs, spi_w} !== 11'b000_000_00_110) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required 00000000110", {busy, done, error, err_code, card_v2, cmd_w, sel, spi_cs, spi_w});
        end
        n_cmp++;
        if (cmd !== 48'h0 || spi_data !== 8'hFF) begin
            n_bad++; $display("FAIL reset_data: cmd=%h spi_data=%h, required 0 ff", cmd, spi_data);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || sel !== 1'b1 || spi_w !== 1'b0 || cmd_w !== 1'b0) begin
            n_bad++; $display("FAIL idle_quiet: busy=%b sel=%b spi_w=%b cmd_w=%b, required 0 1 0 0", busy, sel, spi_w, cmd_w);
        end
    endtask

    task automatic test_v2_nominal();
        int p, cc, ec;
        set_profile(8'h01, 40'h01_000001AA, 2, 8'h00);
        push_seq(1'b1, 3, 1'b1);
        start_pulse();
        run_to_end(1000, -1, -1, 1'b0, p, cc, ec);
        n_cmp++;
        if (p !== 10) begin n_bad++; $display("FAIL v2_dummy_bytes: got %0d, required 10", p); end
        n_cmp++;
        if ({done, error, card_v2, busy, sel} !== 5'b10100) begin
            n_bad++; $display("FAIL v2_status: got %b, required 10100", {done, error, card_v2, busy, sel});
        end
    endtask

    task automatic test_v1_card();
        int p, cc, ec;
        set_profile(8'h01, 40'h05_00000000, 0, 8'h00);
        push_seq(1'b0, 1, 1'b1);
        start_pulse();
        run_to_end(1000, -1, -1, 1'b0, p, cc, ec);
        n_cmp++;
        if ({done, error, card_v2, p == 10} !== 4'b1001) begin
            n_bad++; $display("FAIL v1_status: done=%b error=%b card_v2=%b pulses=%0d, required 1 0 0 10", done, error, card_v2, p);
        end
    endtask

    task automatic test_error(input logic [7:0] r0, input logic [39:0] r8, input int a41_busy,
                              input int n_cmd0, input int a41_iters, input logic [2:0] code, input string tag);
        int p, cc, ec;
        set_profile(r0, r8, a41_busy, 8'h00);
        if (n_cmd0 > 1) begin
            for (int i = 0; i < n_cmd0; i++) exp_q.push_back(F_CMD0);
        end else begin
            push_seq(1'b1, a41_iters, 1'b0);
        end
        start_pulse();
        run_to_end(1000, -1, -1, 1'b0, p, cc, ec);
        n_cmp++;
        if ({error, done, busy, sel} !== 4'b1000 || err_code !== code) begin
            n_bad++;
            $display("FAIL %s: error=%b done=%b busy=%b sel=%b code=%0d, required 1 0 0 0 code %0d", tag, error, done, busy, sel, err_code, code);
        end
    endtask

    task automatic test_watchdog_restart();
        int p, cc, ec;
        set_profile(8'h01, 40'h01_000001AA, 2, 8'h00);
        eng_dead = 1'b1;
        exp_q.push_back(F_CMD0);
        start_pulse();
        run_to_end(1000, -1, -1, 1'b0, p, cc, ec);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 3'd6) begin
            n_bad++; $display("FAIL wdog_code: error=%b code=%0d, required 1 6", error, err_code);
        end
        n_cmp++;
        if (cc < 0 || ec - cc < 49 || ec - cc > 52) begin
            n_bad++; $display("FAIL wdog_latency: got %0d cycles, required 49..52", ec - cc);
        end
        eng_dead = 1'b0;
        push_seq(1'b1, 3, 1'b1);
        start_pulse();
        run_to_end(1000, -1, -1, 1'b0, p, cc, ec);
        n_cmp++;
        if ({done, error, card_v2, p == 10} !== 4'b1011) begin
            n_bad++; $display("FAIL wdog_restart: done=%b error=%b card_v2=%b pulses=%0d, required 1 0 1 10", done, error, card_v2, p);
        end
    endtask

    task automatic test_back_to_back();
        int p, cc, ec;
        set_profile(8'h01, 40'h01_000001AA, 2, 8'h00);
        push_seq(1'b1, 3, 1'b1);
        start_pulse();
        run_to_end(1000, 20, 100, 1'b0, p, cc, ec);
        n_cmp++;
        if ({done, error, p == 10} !== 3'b101) begin
            n_bad++; $display("FAIL start_while_busy: done=%b error=%b pulses=%0d, required 1 0 10", done, error, p);
        end
    endtask

    task automatic test_reset_mid();
        int p, cc, ec;
        int strobes = 0;
        set_profile(8'h01, 40'h01_000001AA, 2, 8'h00);
        push_seq(1'b1, 1, 1'b0);
        start_pulse();
        run_to_end(1000, -1, -1, 1'b1, p, cc, ec);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, sel, cmd_w, spi_w, done, error, card_v2} !== 7'b0100000 || cmd !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b sel=%b cmd_w=%b spi_w=%b card_v2=%b cmd=%h, required 0 1 0 0 0 0", busy, sel, cmd_w, spi_w, card_v2, cmd);
        end
        repeat (3) begin @(negedge clk); if (cmd_w || spi_w || busy) strobes++; end
        reset = 1'b0;
        repeat (6) begin @(negedge clk); if (cmd_w || spi_w || busy) strobes++; end
        n_cmp++;
        if (strobes != 0) begin n_bad++; $display("FAIL reset_quiet: %0d active cycles, required 0", strobes); end
    endtask

    initial begin
        test_reset();
        test_v2_nominal();
        test_v1_card();
        test_error(8'hFF, 40'h01_000001AA, 0, 8, 0, 3'd1, "cmd0_retries");
        test_error(8'h01, 40'h01_000001AB, 0, 1, 0, 3'd2, "cmd8_echo");
        test_error(8'h01, 40'h01_000001AA, 1000, 1, 4, 3'd3, "acmd41_stuck");
        test_watchdog_restart();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_init_seq.md
# sd_init_seq

SD-card SPI-mode initialization sequencer. It sits between the system controller and the SD command engine and owns the SPI bus during power-up. It first clocks out dummy bytes with CS deasserted. It then drives the command engine through the CMD0, CMD8, CMD55/ACMD41 loop and CMD16. It reports card version, completion or a coded error, then hands the SPI bus to the command engine.

## Interface
- `DUMMY_BYTES`, 10: 0xFF bytes sent with CS high (10 × 8 = 80 SCLK cycles).
- `CMD0_TRIES`, 8: CMD0 attempts before error.
- `ACMD41_TRIES`, 1000: CMD55+ACMD41 iterations before error.
- `WAIT_TIMEOUT`, 1_000_000: max clk cycles in any wait state.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin initialization; single-cycle pulse.
- `busy` out 1: high from accepted start until DONE/ERROR.
- `done` out 1: level, high in DONE.
- `error` out 1: level, high in ERROR.
- `err_code` out 3: valid while error=1.
- `card_v2` out 1: CMD8 accepted (SD v2; HCS used).
- `cmd_w` out 1: command-engine write strobe, one cycle.
- `cmd` out 48: command frame, held stable from cmd_w until the response is evaluated.
- `cmd_busy` in 1: command-engine busy.
- `cmd_resp` in 40: engine response; R1 = [39:32], R7 echo = [11:0].
- `sel` out 1: SPI mux select. 1 = this block drives SPI directly; 0 = command engine.
- `spi_cs` out 1: direct-mode CS (1 = deselected).
- `spi_w` out 1: direct-mode byte strobe.
- `spi_data` out 8: constant 8'hFF.
- `spi_busy` in 1: SPI master busy.

## Operation
- States: IDLE, DUMMY_W, DUMMY_WAIT, ISSUE, CMD_START, CMD_DONE, EVAL, DONE, ERROR.
- An internal step register selects the command: CMD0, CMD8, CMD55, ACMD41, CMD16.
- IDLE
  - sel=1, spi_cs=1, outputs quiet.
  - start → DUMMY_W; clear all counters and card_v2.
- DUMMY_W
  - Pulse spi_w, then go to DUMMY_WAIT.
- DUMMY_WAIT
  - Wait for spi_busy rising, then falling. Increment the byte count.
  - Count == DUMMY_BYTES → sel=0, step=CMD0, go to ISSUE. Otherwise go to DUMMY_W.
- ISSUE
  - Requires cmd_busy=0, else hold.
  - Load cmd for the current step and pulse cmd_w, then go to CMD_START.
  - Frames:
    - CMD0 = 48'h40_00000000_95
    - CMD8 = 48'h48_000001AA_87
    - CMD55 = 48'h77_00000000_65
    - ACMD41 = 48'h69_40000000_77 if card_v2, else 48'h69_00000000_E5
    - CMD16 = 48'h50_00000200_15
- CMD_START
  - Wait for cmd_busy=1, then go to CMD_DONE.
- CMD_DONE
  - Wait for cmd_busy=0, then go to EVAL. The response is sampled in EVAL.
- EVAL, by step (R1 = cmd_resp[39:32]):
  - CMD0: R1==8'h01 → CMD8. Else retry; after CMD0_TRIES failures → ERROR code 1.
  - CMD8:
    - R1[2]=1 (illegal command) → card_v2=0, go to CMD55.
    - R1==8'h01 and echo==12'h1AA → card_v2=1, go to CMD55.
    - Otherwise → ERROR code 2.
  - CMD55: R1[7:1]!=0 → ERROR code 4; else go to ACMD41.
  - ACMD41:
    - R1==8'h00 → CMD16.
    - R1==8'h01 → increment the try count and go to CMD55; count reaching ACMD41_TRIES → ERROR code 3.
    - Otherwise → ERROR code 4.
  - CMD16: R1==8'h00 → DONE; else ERROR code 5.
- Watchdog: a cycle counter is cleared on every state change. Reaching WAIT_TIMEOUT in DUMMY_WAIT, CMD_START or CMD_DONE → ERROR code 6.
- DONE / ERROR
  - sel=0; status levels held.
  - start → restart from DUMMY_W (sel=1, status cleared).
- start while busy=1 is ignored.

## Timing
- Reset values:
  - busy=0, done=0, error=0, err_code=0, card_v2=0
  - cmd_w=0, cmd=48'h0
  - sel=1, spi_cs=1, spi_w=0, spi_data=8'hFF
  - counters=0, state IDLE
- start sampled high in IDLE → busy=1 and spi_w=1 on the next cycle.
- cmd_w is registered: high exactly one cycle, the cycle after entering ISSUE with cmd_busy=0.
- EVAL lasts one cycle. The next cmd_w comes at least 2 cycles after cmd_busy falls.
- spi_cs stays 1 throughout direct mode. sel switches 1→0 on the same edge DUMMY_WAIT exits.
- Reset asserted mid-operation → IDLE on the next edge. No further strobes; all outputs return to reset values.

## Test plan
- Nominal v2 card: CMD0 → 8'h01; CMD8 → 40'h01_000001AA; ACMD41 → 8'h01 twice then 8'h00; CMD16 → 8'h00. Expect 10 spi_w pulses, then the exact frame sequence CMD0, CMD8, (CMD55, ACMD41 48'h69_40000000_77) ×3, CMD16; done=1, card_v2=1.
- v1 card: CMD8 → R1=8'h05. Expect card_v2=0, ACMD41 frame 48'h69_00000000_E5, done=1.
- CMD0 always returns 8'hFF → exactly 8 CMD0 frames, then error=1, err_code=1.
- CMD8 echo 12'h1AB → error, err_code=2. ACMD41 stuck at 8'h01 with ACMD41_TRIES=4 → 4 iterations, err_code=3.
- cmd_busy never rises, WAIT_TIMEOUT=50 → err_code=6 within 52 cycles. Then pulse start → full sequence restarts.
- Reset asserted during the ACMD41 loop → next cycle busy=0, sel=1, cmd_w=0. A start pulse while busy=1 changes nothing.
